// File: rtl/mem_mmio_ctrl_if.sv
// rtl/mem_mmio_ctrl_if.sv - request/acknowledge bus between the CPU data path and mem_mmio_ctrl
//   req/we/addr/wdata : master -> slave, sampled by the slave only while idle
//   rdata/ack/err     : slave -> master, valid in the single ack cycle
//   busy              : slave -> master, high from accept through the ack cycle
interface mem_mmio_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 9
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              err;
    logic              busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, err, busy
    );
endinterface

// File: rtl/mem_mmio_ctrl.sv
// rtl/mem_mmio_ctrl.sv - parametrised RAM plus memory-mapped switch/LED controller with wait states
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset (RAM contents are kept)
//   bus       : slave side of the req/ack access port
//   in_ports  : asynchronous switch inputs, port i at [i*DATA_W +: DATA_W]
//   out_ports : registered LED outputs, same packing
module mem_mmio_ctrl #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned N_IN        = 2,
    parameter int unsigned N_OUT       = 2,
    parameter int unsigned IN_BASE     = 'h140,
    parameter int unsigned OUT_BASE    = 'h100,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_mmio_ctrl_if.slave          bus,
    input  logic [N_IN*DATA_W-1:0]  in_ports,
    output logic [N_OUT*DATA_W-1:0] out_ports
);
    localparam int unsigned RAM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    // Window bounds carry one extra bit so that an end bound equal to 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] RAM_END = (ADDR_W+1)'(MEM_WORDS);
    localparam logic [ADDR_W:0] OUT_LO  = (ADDR_W+1)'(OUT_BASE);
    localparam logic [ADDR_W:0] OUT_HI  = (ADDR_W+1)'(OUT_BASE + N_OUT);
    localparam logic [ADDR_W:0] IN_LO   = (ADDR_W+1)'(IN_BASE);
    localparam logic [ADDR_W:0] IN_HI   = (ADDR_W+1)'(IN_BASE + N_IN);

    generate
        if (OUT_BASE < MEM_WORDS || IN_BASE < MEM_WORDS ||
            (OUT_BASE < IN_BASE + N_IN && IN_BASE < OUT_BASE + N_OUT)) begin : g_overlap
            $error("mem_mmio_ctrl: RAM, OUT and IN address windows overlap");
        end
        if (WAIT_CYCLES > 15) begin : g_wait_range
            $error("mem_mmio_ctrl: WAIT_CYCLES must be 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
    typedef enum logic [1:0] {R_RAM, R_OUT, R_IN, R_ILL} region_e;

    function automatic region_e decode(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] ax;
        ax = {1'b0, a};
        if (ax < RAM_END)                return R_RAM;
        if (ax >= OUT_LO && ax < OUT_HI) return R_OUT;
        if (ax >= IN_LO && ax < IN_HI)   return R_IN;
        return R_ILL;
    endfunction

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] pdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] in_s1_q [N_IN];
    logic [DATA_W-1:0] in_s2_q [N_IN];
    logic [DATA_W-1:0] out_q   [N_OUT];
    logic [DATA_W-1:0] mem_q   [MEM_WORDS];

    logic              accept;
    logic              enter_resp;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_we;
    region_e           cur_region;
    logic              cur_illegal;
    logic [DATA_W-1:0] port_val;
    logic [DATA_W-1:0] rd_val;
    region_e           region_q;
    logic              illegal_q;
    logic              commit;
    logic [N_OUT-1:0]  out_wr;

    assign accept     = (state_q == S_IDLE) && bus.req;
    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    // While idle the access being accepted is still on the bus; afterwards it lives in the
    // latched copy. With zero wait states RESP follows IDLE directly, so the RAM read address
    // has to come straight from the bus.
    always_comb begin
        cur_addr    = (state_q == S_IDLE) ? bus.addr : addr_q;
        cur_we      = (state_q == S_IDLE) ? bus.we   : we_q;
        cur_region  = decode(cur_addr);
        cur_illegal = (cur_region == R_ILL) || (cur_region == R_IN && cur_we);
        port_val    = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (cur_region == R_IN && cur_addr == ADDR_W'(IN_BASE + i))
                port_val = in_s2_q[i];
        end
        for (int i = 0; i < int'(N_OUT); i++) begin
            if (cur_region == R_OUT && cur_addr == ADDR_W'(OUT_BASE + i))
                port_val = out_q[i];
        end
    end

    // Port data is snapshotted at accept so a switch read sees the value synchronised at
    // request time; RAM data is fetched on the edge entering RESP.
    always_comb begin
        if (cur_illegal || cur_we)
            rd_val = '0;
        else if (cur_region == R_RAM)
            rd_val = mem_q[cur_addr[RAM_AW-1:0]];
        else if (state_q == S_IDLE)
            rd_val = port_val;
        else
            rd_val = pdata_q;
    end

    always_comb begin
        region_q  = decode(addr_q);
        illegal_q = (region_q == R_ILL) || (region_q == R_IN && we_q);
        commit    = (state_q == S_RESP) && we_q && !illegal_q;
        out_wr    = '0;
        for (int i = 0; i < int'(N_OUT); i++) begin
            out_wr[i] = commit && (region_q == R_OUT) && (addr_q == ADDR_W'(OUT_BASE + i));
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1)
                    state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.ack   = (state_q == S_RESP);
        bus.err   = (state_q == S_RESP) && illegal_q;
        bus.busy  = (state_q != S_IDLE);
        bus.rdata = rdata_q;
    end

    // An OUT write is committed on the edge leaving RESP but already drives the LEDs during
    // the ack cycle; a reset inside RESP drops it together with the register contents.
    always_comb begin
        out_ports = '0;
        for (int i = 0; i < int'(N_OUT); i++) begin
            out_ports[i*DATA_W +: DATA_W] = out_wr[i] ? wdata_q : out_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pdata_q <= '0;
            rdata_q <= '0;
            for (int i = 0; i < int'(N_IN); i++) begin
                in_s1_q[i] <= '0;
                in_s2_q[i] <= '0;
            end
            for (int i = 0; i < int'(N_OUT); i++) begin
                out_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_IN); i++) begin
                in_s1_q[i] <= in_ports[i*DATA_W +: DATA_W];
                in_s2_q[i] <= in_s1_q[i];
            end
            if (accept) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                pdata_q <= port_val;
            end
            if (enter_resp)
                rdata_q <= rd_val;
            for (int i = 0; i < int'(N_OUT); i++) begin
                if (out_wr[i])
                    out_q[i] <= wdata_q;
            end
        end
    end

    // RAM has no reset so its contents survive a reset of the controller.
    always_ff @(posedge clk) begin
        if (commit && region_q == R_RAM)
            mem_q[addr_q[RAM_AW-1:0]] <= wdata_q;
    end
endmodule

// File: tb/tb_mem_mmio_ctrl.sv
// tb/tb_mem_mmio_ctrl.sv - self-checking bench for mem_mmio_ctrl at 0, 1 and 3 wait states
module tb_mem_mmio_ctrl;
    localparam int         NDUT     = 3;
    localparam logic [8:0] IN_BASE  = 9'h140;
    localparam logic [8:0] OUT_BASE = 9'h100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NDUT-1:0]       rst_a, req_a, we_a;
    logic [NDUT-1:0][8:0]  addr_a;
    logic [NDUT-1:0][15:0] wdata_a;
    wire  [NDUT-1:0]       ack_a, err_a, busy_a;
    wire  [NDUT-1:0][15:0] rdata_a;
    wire  [NDUT-1:0][31:0] out_a;
    logic [31:0]           in_ports;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_mmio_ctrl_if #(.DATA_W(16), .ADDR_W(9)) bus ();
        assign bus.req    = req_a[g];
        assign bus.we     = we_a[g];
        assign bus.addr   = addr_a[g];
        assign bus.wdata  = wdata_a[g];
        assign rdata_a[g] = bus.rdata;
        assign ack_a[g]   = bus.ack;
        assign err_a[g]   = bus.err;
        assign busy_a[g]  = bus.busy;
        mem_mmio_ctrl #(
            .DATA_W(16), .ADDR_W(9), .MEM_WORDS(256), .N_IN(2), .N_OUT(2),
            .IN_BASE('h140), .OUT_BASE('h100),
            .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3))
        ) dut (
            .clk(clk),
            .reset(rst_a[g]),
            .bus(bus),
            .in_ports(in_ports),
            .out_ports(out_a[g])
        );
    end

    typedef struct {
        bit         w;
        logic [8:0] a;
        logic [15:0] d;
        bit         chk_rd;
        logic [15:0] rd;
        bit         er;
    } vec_t;

    vec_t        tbl [13];
    logic [15:0] ref_mem [NDUT][256];
    bit          ref_val [NDUT][256];
    logic [15:0] ref_out [NDUT][2];
    logic [8:0]  ill_tab [5] = '{9'h102, 9'h13F, 9'h142, 9'h1FF, 9'h1A0};
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    // 0 = RAM, 1 = OUT, 2 = IN, 3 = unmapped
    function automatic int region(input logic [8:0] a);
        if (a < 256) return 0;
        if (a >= OUT_BASE && a < OUT_BASE + 2) return 1;
        if (a >= IN_BASE && a < IN_BASE + 2) return 2;
        return 3;
    endfunction

    task automatic model_commit(input int k, input bit w, input logic [8:0] a, input logic [15:0] d);
        int rg;
        rg = region(a);
        if (w && rg == 0) begin
            ref_mem[k][int'(a)] = d;
            ref_val[k][int'(a)] = 1'b1;
        end else if (w && rg == 1) begin
            ref_out[k][int'(a) - int'(OUT_BASE)] = d;
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the edge closing RESP.
    task automatic access(input int k, input bit w, input logic [8:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] rd, output logic er,
                          output logic [31:0] op);
        bit done;
        lat = -1; rd = '0; er = 1'b0; op = '0; done = 1'b0;
        we_a[k] = w; addr_a[k] = a; wdata_a[k] = d; req_a[k] = 1'b1;
        @(posedge clk); #1;
        req_a[k] = 1'b0;
        for (int i = 1; i <= 40 && !done; i++) begin
            @(negedge clk);
            if (ack_a[k]) begin
                lat = i; rd = rdata_a[k]; er = err_a[k]; op = out_a[k]; done = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_op(input int k, input bit w, input logic [8:0] a, input logic [15:0] d,
                         input bit chk_rd, input logic [15:0] exp_rd, input bit exp_err,
                         input string nm);
        int lat; logic [15:0] rd; logic er; logic [31:0] op;
        access(k, w, a, d, lat, rd, er, op);
        model_commit(k, w, a, d);
        chk({nm, "/latency"}, lat, wait_of(k) + 1);
        chk({nm, "/err"}, er, exp_err);
        if (chk_rd) chk({nm, "/rdata"}, rd, exp_rd);
        chk({nm, "/out_ports"}, op, {ref_out[k][1], ref_out[k][0]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          rg, sel, nack, idx;
        bit          w, e_err, c_rd, seen, ack_seen;
        logic [8:0]  a;
        logic [15:0] d, e_rd;

        //              w  addr     wdata    chk  rdata    err
        tbl[0]  = '{1, 9'h008, 16'd24,   0, 16'h0000, 0};
        tbl[1]  = '{0, 9'h008, 16'h0,    1, 16'd24,   0};
        tbl[2]  = '{1, 9'h100, 16'd48,   0, 16'h0000, 0};
        tbl[3]  = '{0, 9'h100, 16'h0,    1, 16'd48,   0};
        tbl[4]  = '{0, 9'h101, 16'h0,    1, 16'h0000, 0};
        tbl[5]  = '{0, 9'h140, 16'h0,    1, 16'h0008, 0};
        tbl[6]  = '{0, 9'h141, 16'h0,    1, 16'h00A5, 0};
        tbl[7]  = '{1, 9'h140, 16'hFFFF, 1, 16'h0000, 1};
        tbl[8]  = '{0, 9'h1FF, 16'h0,    1, 16'h0000, 1};
        tbl[9]  = '{1, 9'h102, 16'h1234, 1, 16'h0000, 1};
        tbl[10] = '{1, 9'h0FF, 16'hBEEF, 0, 16'h0000, 0};
        tbl[11] = '{0, 9'h0FF, 16'h0,    1, 16'hBEEF, 0};
        tbl[12] = '{0, 9'h140, 16'h0,    1, 16'h0008, 0};

        for (int k = 0; k < NDUT; k++) begin
            for (int j = 0; j < 256; j++) begin
                ref_mem[k][j] = '0;
                ref_val[k][j] = 1'b0;
            end
            ref_out[k][0] = '0;
            ref_out[k][1] = '0;
        end

        rst_a = '1; req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
        in_ports = 32'h00A5_0008;
        repeat (3) @(posedge clk);
        #1 rst_a = '0;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("reset/ack%0d", k),   ack_a[k],   1'b0);
            chk($sformatf("reset/err%0d", k),   err_a[k],   1'b0);
            chk($sformatf("reset/busy%0d", k),  busy_a[k],  1'b0);
            chk($sformatf("reset/rdata%0d", k), rdata_a[k], 16'h0);
            chk($sformatf("reset/out%0d", k),   out_a[k],   32'h0);
        end
        repeat (3) @(posedge clk);
        #1;

        // Directed table on every wait-state variant
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 13; i++) begin
                do_op(k, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].chk_rd, tbl[i].rd, tbl[i].er,
                      $sformatf("tbl%0d/dut%0d", i, k));
            end
        end

        // Randomised accesses against the reference model
        for (int k = 0; k < NDUT; k++) begin
            for (int n = 0; n < 40; n++) begin
                if (n % 10 == 0) begin
                    in_ports = $urandom;
                    repeat (3) @(posedge clk);
                    #1;
                end
                sel = $urandom_range(0, 9);
                w   = 1'($urandom_range(0, 1));
                d   = 16'($urandom);
                case (sel)
                    0, 1, 2, 3: a = 9'($urandom_range(0, 15));
                    4, 5:       a = 9'($urandom_range(0, 255));
                    6:          a = OUT_BASE + 9'($urandom_range(0, 1));
                    7:          a = IN_BASE + 9'($urandom_range(0, 1));
                    8:          a = ill_tab[$urandom_range(0, 4)];
                    default:    a = $urandom_range(0, 1) ? 9'h0FF : 9'h100;
                endcase
                rg    = region(a);
                e_err = (rg == 3) || (rg == 2 && w);
                c_rd  = 1'b0;
                e_rd  = '0;
                if (e_err) begin
                    c_rd = 1'b1;
                end else if (!w) begin
                    if (rg == 0) begin
                        c_rd = ref_val[k][int'(a)];
                        e_rd = ref_mem[k][int'(a)];
                    end else if (rg == 1) begin
                        c_rd = 1'b1;
                        e_rd = ref_out[k][int'(a) - int'(OUT_BASE)];
                    end else begin
                        idx  = int'(a) - int'(IN_BASE);
                        c_rd = 1'b1;
                        e_rd = in_ports[idx*16 +: 16];
                    end
                end
                do_op(k, w, a, d, c_rd, e_rd, e_err, $sformatf("rand%0d/dut%0d/a%0h", n, k, a));
            end
        end

        // Switch synchronisation: a change one cycle before req is not yet visible
        in_ports = 32'h0000_0008;
        repeat (3) @(posedge clk);
        #1;
        in_ports = 32'h0000_0055;
        @(posedge clk); #1;
        do_op(1, 1'b0, IN_BASE, 16'h0, 1'b1, 16'h0008, 1'b0, "sync/late_change");
        in_ports = 32'h0000_0077;
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_op(1, 1'b0, IN_BASE, 16'h0, 1'b1, 16'h0077, 1'b0, "sync/settled");

        // Reset in the middle of a 3-wait-state write aborts it
        do_op(2, 1'b1, OUT_BASE, 16'h003C, 1'b0, 16'h0, 1'b0, "abort/prewrite");
        we_a[2] = 1'b1; addr_a[2] = 9'h008; wdata_a[2] = 16'h0018; req_a[2] = 1'b1;
        @(posedge clk); #1;
        req_a[2] = 1'b0;
        @(posedge clk); #1;
        chk("abort/busy_before", busy_a[2], 1'b1);
        rst_a[2] = 1'b1;
        #1;
        chk("abort/busy_now", busy_a[2], 1'b0);
        chk("abort/ack_now",  ack_a[2],  1'b0);
        chk("abort/out_now",  out_a[2],  32'h0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ack_a[2]) seen = 1'b1;
            if (c == 1) rst_a[2] = 1'b0;
        end
        @(posedge clk); #1;
        chk("abort/no_ack", seen, 1'b0);
        ref_out[2][0] = '0;
        ref_out[2][1] = '0;
        do_op(2, 1'b0, 9'h008, 16'h0, ref_val[2][8], ref_mem[2][8], 1'b0, "abort/mem8");

        // Back-to-back reads with req held high, zero wait states
        for (int i = 0; i < 4; i++) begin
            do_op(0, 1'b1, 9'(i), 16'hA000 + 16'(i * 'h111), 1'b0, 16'h0, 1'b0,
                  $sformatf("b2b/fill%0d", i));
        end
        we_a[0] = 1'b0; addr_a[0] = 9'h000; req_a[0] = 1'b1;
        nack = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            ack_seen = ack_a[0];
            chk($sformatf("b2b/ack_c%0d", c),  ack_a[0],  1'((c % 2 == 1) && (c < 8)));
            chk($sformatf("b2b/busy_c%0d", c), busy_a[0], 1'((c % 2 == 1) && (c < 8)));
            if (ack_seen) begin
                chk($sformatf("b2b/rdata%0d", nack), rdata_a[0], ref_mem[0][nack]);
                nack++;
            end
            @(posedge clk); #1;
            if (ack_seen) begin
                addr_a[0] = 9'(nack);
                if (nack == 4) req_a[0] = 1'b0;
            end
        end
        req_a[0] = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_mmio_ctrl.md
Name: mem_mmio_ctrl

Overview:
- Parametrised memory and memory-mapped I/O controller for the RISC CPU data path.
- Replaces the fixed one-cycle RAM plus hard-wired switch/LED decode with a request/acknowledge port.
- Address width, RAM depth, number of input and output ports, and wait-state count are all configurable.
- Sits between the CPU's LDR/STR sequencing and the board I/O (SW, LEDR).

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 9, address width; matches the PC/address register.
- MEM_WORDS, 256, RAM depth; valid RAM addresses are 0..MEM_WORDS-1.
- N_IN, 2, number of read-only input ports.
- N_OUT, 2, number of read/write output ports.
- IN_BASE, 9'h140, address of input port 0; port i is at IN_BASE+i.
- OUT_BASE, 9'h100, address of output port 0; port i is at OUT_BASE+i.
- WAIT_CYCLES, 1, extra cycles between request and ack (0..15).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  access address; sampled with req.
- wdata  in  DATA_W  write data; sampled with req.
- rdata  out  DATA_W  read data; valid while ack=1.
- ack  out  1  one-cycle completion pulse.
- err  out  1  qualifies ack: the access was illegal.
- busy  out  1  high from accept until and including the ack cycle.
- in_ports  in  N_IN*DATA_W  asynchronous inputs (switches); port i occupies bits [i*DATA_W +: DATA_W].
- out_ports  out  N_OUT*DATA_W  registered outputs (LEDs); same packing as in_ports.

Behaviour:
- Reset values:
  - rdata, ack, err, busy = 0.
  - out_ports all 0; FSM in IDLE; wait counter 0.
  - Input synchronisers cleared to 0.
  - RAM contents are NOT affected by reset; RAM is loaded from an init file at elaboration.
- Input synchronisation: each in_ports bit passes through a 2-flop synchroniser. Reads return the synchronised value, so a change is visible 2 cycles later.
- Address decode, evaluated on the latched address:
  - RAM if addr < MEM_WORDS.
  - OUT port if OUT_BASE <= addr < OUT_BASE+N_OUT.
  - IN port if IN_BASE <= addr < IN_BASE+N_IN.
  - Otherwise ILLEGAL.
  - Overlapping windows are an elaboration error (assertion).
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on req=1, latch we/addr/wdata, set busy=1, load counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else RESP.
  - WAIT: decrement the counter; go to RESP when it reaches 1.
  - RESP: ack=1 for exactly one cycle, then return to IDLE. busy falls the cycle after ack.
  - Latency from the req-sampling edge to ack high is WAIT_CYCLES+1 cycles.
- Commit rule: RAM and OUT-port writes take effect on the edge that leaves RESP, in the same cycle ack is visible.
  - A reset asserted before that edge aborts the access: no write, no ack.
- Read data:
  - RAM reads are synchronous; the address is presented in the cycle before RESP.
  - OUT-port reads return the current register value (read-back).
  - IN-port reads return the synchronised input.
- Errors, all with ack=1, err=1, rdata=0 and no state change:
  - Write to an IN port.
  - Any access to ILLEGAL.
- Back-to-back: req held high is accepted again in the IDLE cycle after RESP. Minimum period is WAIT_CYCLES+2 cycles per access.
- req during WAIT/RESP is ignored and not queued.
- Address wrap: no wrap. An address of exactly MEM_WORDS is ILLEGAL unless it is mapped to a port.
- rdata holds its last value outside ack; only the ack-cycle value is specified.

Test Plan:
- Reset mid-access with WAIT_CYCLES=3: write 16'h0018 to addr 8, assert reset during WAIT → no ack pulse, mem[8] unchanged, out_ports=0, busy=0 immediately.
- RAM round trip with WAIT_CYCLES=1: write 16'd24 to addr 8, then read addr 8 → each ack arrives 2 cycles after req, rdata=24, err=0.
- Switch read: in_ports port 0 = 16'h0008, read IN_BASE → rdata=8, but only if in_ports was stable for ≥2 cycles before req; a change 1 cycle before req returns the old value.
- LED write/read-back: write 16'd48 to OUT_BASE, then read OUT_BASE → out_ports[15:0]=48 on the ack cycle, read-back 48; port 1 stays 0.
- Error cases: write to IN_BASE, read addr 9'h1FF → both give ack=1, err=1, rdata=0, and port/RAM state is unchanged.
- Back-to-back with req held high, WAIT_CYCLES=0: four reads of addr 0..3 → exactly one ack every 2 cycles, in order, with correct RAM data; busy toggles as specified.
